// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, failure codes
// and an index-width helper that keeps single-entry tables at one bit.
package mwc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ADDR    = 2'd1,
        FC_DATA    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Snooped store bus of the core: strobe, address and data.
interface mem_write_checker_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker_match_unit.sv
// Combinational compare of one store against every expected entry, with
// lowest-index encoders and the selected entry for in-order checking.
module mwc_match_unit
    import mwc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int NEXP = 4,
    localparam int IW  = idx_w(NEXP)
) (
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      data,
    input  logic [NEXP*AW-1:0] exp_addr,
    input  logic [NEXP*DW-1:0] exp_data,
    input  logic [NEXP-1:0]    hit,
    input  logic [IW-1:0]      idx,
    output logic [NEXP-1:0]    addr_hit,
    output logic [NEXP-1:0]    pair_hit,
    output logic [NEXP-1:0]    free_hit,
    output logic [IW-1:0]      addr_idx,
    output logic [IW-1:0]      free_idx,
    output logic               ord_addr,
    output logic               ord_pair
);

    for (genvar i = 0; i < NEXP; i++) begin : g_ent
        assign addr_hit[i] = (addr == exp_addr[i*AW +: AW]);
        assign pair_hit[i] = addr_hit[i] && (data == exp_data[i*DW +: DW]);
    end

    // entries already consumed can no longer absorb a write
    assign free_hit = pair_hit & ~hit;

    always_comb begin
        addr_idx = '0;
        free_idx = '0;
        ord_addr = 1'b0;
        ord_pair = 1'b0;
        for (int i = NEXP - 1; i >= 0; i--) begin
            if (addr_hit[i]) addr_idx = IW'(i);
            if (free_hit[i]) free_idx = IW'(i);
            if (idx == IW'(i)) begin
                ord_addr = addr_hit[i];
                ord_pair = pair_hit[i];
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Store snooper that checks writes against an expected table, with sticky
// pass/fail, failure code/index, match and cycle counters plus a timeout.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int NEXP    = 4,
    parameter int ORDERED = 1,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16,
    localparam int IW     = idx_w(NEXP),
    localparam int CNTW   = $clog2(NEXP + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    mem_write_checker_if.slave  bus,
    input  logic [NEXP*AW-1:0]  exp_addr,
    input  logic [NEXP*DW-1:0]  exp_data,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output fail_code_t          fail_code,
    output logic [IW-1:0]       fail_idx,
    output logic [CNTW-1:0]     match_cnt,
    output logic [CW-1:0]       cycle_cnt
);

    state_t            state;
    logic [NEXP-1:0]   hit, hit_set;
    logic [NEXP-1:0]   addr_hit, pair_hit, free_hit;
    logic [IW-1:0]     addr_idx, free_idx, idx_nxt;
    logic              ord_addr, ord_pair;
    logic              adv, ev_pass, ev_fail;
    logic [CNTW-1:0]   cnt_inc;
    fail_code_t        code_nxt;

    mwc_match_unit #(.DW(DW), .AW(AW), .NEXP(NEXP)) u_match (
        .addr     (bus.dataadr),
        .data     (bus.writedata),
        .exp_addr (exp_addr),
        .exp_data (exp_data),
        .hit      (hit),
        .idx      (IW'(match_cnt)),
        .addr_hit (addr_hit),
        .pair_hit (pair_hit),
        .free_hit (free_hit),
        .addr_idx (addr_idx),
        .free_idx (free_idx),
        .ord_addr (ord_addr),
        .ord_pair (ord_pair)
    );

    assign cnt_inc = match_cnt + CNTW'(1);

    always_comb begin
        adv      = 1'b0;
        ev_fail  = 1'b0;
        code_nxt = FC_NONE;
        idx_nxt  = '0;
        hit_set  = '0;
        if (state == RUN && bus.memwrite) begin
            if (ORDERED != 0) begin
                if (ord_pair) begin
                    adv = 1'b1;
                end else begin
                    ev_fail  = 1'b1;
                    code_nxt = ord_addr ? FC_DATA : FC_ADDR;
                    idx_nxt  = IW'(match_cnt);
                end
            end else if (|free_hit) begin
                adv     = 1'b1;
                hit_set = free_hit & (~free_hit + NEXP'(1));
            end else if (!(|pair_hit) && (|addr_hit)) begin
                // a repeat of a consumed pair lands in pair_hit and is ignored
                ev_fail  = 1'b1;
                code_nxt = FC_DATA;
                idx_nxt  = addr_idx;
            end
        end
        ev_pass = adv && (cnt_inc == CNTW'(NEXP));
        if (TIMEOUT != 0 && state == RUN && !ev_pass && !ev_fail &&
            cycle_cnt == CW'(TIMEOUT - 1)) begin
            ev_fail  = 1'b1;
            code_nxt = FC_TIMEOUT;
            idx_nxt  = (ORDERED != 0) ? (adv ? IW'(cnt_inc) : IW'(match_cnt)) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            hit       <= '0;
        end else if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            hit       <= '0;
        end else if (state == RUN) begin
            if (~&cycle_cnt) cycle_cnt <= cycle_cnt + CW'(1);
            if (adv) match_cnt <= cnt_inc;
            hit <= hit | hit_set;
            if (ev_pass) begin
                state <= PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (ev_fail) begin
                state     <= FAIL;
                busy      <= 1'b0;
                done      <= 1'b1;
                fail      <= 1'b1;
                fail_code <= code_nxt;
                fail_idx  <= idx_nxt;
            end
        end
    end

endmodule
